imm_decode_stage: RTL
=====================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, width of the sideband tag carried with each instruction.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports valid_i input 1, ready_o output 1, instr_i input 32 and tag_i input TAG_WIDTH, forming the upstream valid/ready channel.
REQ-006 SHALL have ports valid_o output 1 and ready_i input 1, forming the downstream valid/ready channel.
REQ-007 SHALL have outputs imm_o (DATA_WIDTH, immediate), imm_type_o (3, 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z), illegal_o (1, unrecognised opcode) and tag_o (TAG_WIDTH, tag of the output entry).

Function
REQ-008 SHALL accept an input on a rising edge where valid_i && ready_o, and transfer an output on a rising edge where valid_o && ready_i.
REQ-009 SHALL register results: an entry accepted at edge N appears on the outputs after edge N, giving 1-cycle latency and full throughput of 1 per cycle.
REQ-010 SHALL contain an output register and one skid register; ready_o = !skid_valid, driven from a flop only with no combinational path from ready_i.
REQ-011 On accept with the output register empty or draining in the same edge and the skid empty, the new entry SHALL load the output register.
REQ-012 On accept with the output register full and not draining, the new entry SHALL load the skid register.
REQ-013 On drain with the skid full, the skid entry SHALL move to the output register; no accept is possible in that cycle because ready_o = 0.
REQ-014 imm_o, imm_type_o, illegal_o and tag_o SHALL hold stable while valid_o && !ready_i; entries SHALL leave in order with no loss or duplication.
REQ-015 Decode SHALL use opcode instr[6:0]: I-type for 0000011, 0001111, 0010011 and 1100111, plus 0011011 when DATA_WIDTH==64.
REQ-016 Decode SHALL give S-type for 0100011, B-type for 1100011, U-type for 0110111 and 0010111, and J-type for 1101111.
REQ-017 Opcodes 0110011 and 1110011, plus 0111011 when DATA_WIDTH==64, SHALL give imm 0, type NONE, illegal 0.
REQ-018 Any other opcode, including instr[1:0] != 2'b11, SHALL give imm 0, type NONE, illegal 1.
REQ-019 I, S, B, U and J immediates SHALL use the standard RISC-V bit placement, B and J with LSB 0, and SHALL be sign-extended from instr[31] to DATA_WIDTH (U-type included, so RV64 LUI is sign-extended).

Reset
REQ-020 While rst_i is high at a rising edge: valid_o = 0, skid empty (ready_o = 1 after the edge), imm_o = 0, imm_type_o = 0, illegal_o = 0, tag_o = 0.
REQ-021 Reset asserted mid-operation SHALL discard both buffered entries; inputs presented during reset SHALL NOT be accepted.

Configuration
REQ-022 Macro IMM_DECODE_ZIMM_EN SHALL enable CSR immediate decode.
REQ-023 With IMM_DECODE_ZIMM_EN defined, opcode 1110011 with instr[14] = 1 SHALL give type Z and imm = zero-extended instr[19:15].
REQ-024 Without IMM_DECODE_ZIMM_EN, opcode 1110011 SHALL give type NONE, imm 0 and illegal 0, and encoding 6 SHALL never be produced.

Verification
REQ-025 SHALL test: addi 0xFFF00093, tag 3, ready_i = 1 -> one cycle after accept valid_o = 1, imm_o = 0xFFFFFFFF, type I, tag_o = 3.
REQ-026 SHALL test: beq 0xFE000EE3 -> imm_o = 0xFFFFFFFC, type B, illegal 0.
REQ-027 SHALL test: ready_i = 0 with tags 1, 2, 3 offered back-to-back -> tags 1 and 2 accepted, ready_o = 0 after the second accept, tag 3 held upstream; then ready_i = 1 -> outputs tags 1, 2, 3 in consecutive cycles.
REQ-028 SHALL test: instr 0x00000000 -> illegal_o = 1, imm_o = 0, type NONE; then pulse rst_i with two entries buffered -> valid_o = 0 and ready_o = 1 after the reset edge.
REQ-029 SHALL test: DATA_WIDTH = 64, lui 0x800000B7 -> imm_o = 0xFFFFFFFF80000000, type U.
REQ-030 SHALL test: csrrwi 0x300FD073 -> with IMM_DECODE_ZIMM_EN imm_o = 0x1F, type Z; without it imm_o = 0, type NONE, illegal 0.

Source files
------------

// File: rtl/imm_decode_stage.sv
// RISC-V immediate decode stage: one-cycle registered decode behind a valid/ready skid buffer.
// Define IMM_DECODE_ZIMM_EN to decode the CSR zero-extended immediate (type Z) for SYSTEM opcodes.
module imm_decode_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           instr_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [2:0]            imm_type_o,
    output logic                  illegal_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5,
        ImmZ    = 3'd6
    } imm_type_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        imm_type_e             ty;
        logic                  ill;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    entry_t             dec;
    logic signed [31:0] imm32;
    logic [6:0]         opcode;

    always_comb begin
        dec     = '0;
        dec.tag = tag_i;
        imm32   = '0;
        opcode  = instr_i[6:0];
        case (opcode)
            7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111: begin
                dec.ty = ImmI;
                imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            7'b0011011: begin
                if (DATA_WIDTH == 64) begin
                    dec.ty = ImmI;
                    imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
                end else begin
                    dec.ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec.ty = ImmS;
                imm32  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            7'b1100011: begin
                dec.ty = ImmB;
                imm32  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.ty = ImmU;
                imm32  = {instr_i[31:12], 12'h000};
            end
            7'b1101111: begin
                dec.ty = ImmJ;
                imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
            end
            7'b0110011: ;
            7'b0111011: begin
                if (DATA_WIDTH != 64) begin
                    dec.ill = 1'b1;
                end
            end
            7'b1110011: begin
`ifdef IMM_DECODE_ZIMM_EN
                if (instr_i[14]) begin
                    dec.ty  = ImmZ;
                    dec.imm = DATA_WIDTH'({27'd0, instr_i[19:15]});
                end
`endif
            end
            default: dec.ill = 1'b1;
        endcase
        // Sign-extend from bit 31 to the full width, U-type included.
        if (dec.ty inside {ImmI, ImmS, ImmB, ImmU, ImmJ}) begin
            dec.imm = DATA_WIDTH'($signed(imm32));
        end
    end

    entry_t out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   accept, drain;

    assign ready_o = !skid_valid_q;
    assign valid_o = out_valid_q;
    assign accept  = valid_i && ready_o;
    assign drain   = out_valid_q && ready_i;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (drain && skid_valid_q) begin
            // ready_o is low here, so no accept can coincide with the skid refill.
            out_d        = skid_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign imm_o      = out_q.imm;
    assign imm_type_o = out_q.ty;
    assign illegal_o  = out_q.ill;
    assign tag_o      = out_q.tag;

endmodule
